// File: rtl/multicycle_ctrl_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_fetch: PC/IR owner and Moore control FSM (IF..WB, HLT)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] IMem_data,
  input  logic        IMem_ready,
  input  logic        PSW_Z,
  output logic        IMem_req,
  output logic [15:0] PC,
  output logic [15:0] Ins,
  output logic        WBRF,
  output logic        RBresource,
  output logic        WBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_IDEXE,
  output logic        ALUop,
  output logic        Flag,
  output logic        DMem_re,
  output logic        DMem_we,
  output logic        Halt,
  output logic        Illegal
);

  localparam logic [2:0] c_ST_IF  = 3'd0;
  localparam logic [2:0] c_ST_ID  = 3'd1;
  localparam logic [2:0] c_ST_EXE = 3'd2;
  localparam logic [2:0] c_ST_MEM = 3'd3;
  localparam logic [2:0] c_ST_WB  = 3'd4;
  localparam logic [2:0] c_ST_HLT = 3'd5;

  localparam logic [4:0] c_OP_NOP  = 5'b00000;
  localparam logic [4:0] c_OP_ADD  = 5'b00001;
  localparam logic [4:0] c_OP_SUB  = 5'b00010;
  localparam logic [4:0] c_OP_LI   = 5'b00100;
  localparam logic [4:0] c_OP_LD   = 5'b00101;
  localparam logic [4:0] c_OP_ST   = 5'b00110;
  localparam logic [4:0] c_OP_B    = 5'b00111;
  localparam logic [4:0] c_OP_BZ   = 5'b01000;
  localparam logic [4:0] c_OP_HALT = 5'b11111;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;

  logic [4:0]  w_op;
  logic        w_is_nop, w_is_add, w_is_sub, w_is_li, w_is_ld;
  logic        w_is_st, w_is_b, w_is_bz, w_is_halt, w_is_legal;
  logic [15:0] w_branch_tgt;
  logic        w_branch_taken;

  assign w_op      = ins_q[15:11];
  assign w_is_nop  = (w_op == c_OP_NOP);
  assign w_is_add  = (w_op == c_OP_ADD);
  assign w_is_sub  = (w_op == c_OP_SUB);
  assign w_is_li   = (w_op == c_OP_LI);
  assign w_is_ld   = (w_op == c_OP_LD);
  assign w_is_st   = (w_op == c_OP_ST);
  assign w_is_b    = (w_op == c_OP_B);
  assign w_is_bz   = (w_op == c_OP_BZ);
  assign w_is_halt = (w_op == c_OP_HALT);
  assign w_is_legal = w_is_nop | w_is_add | w_is_sub | w_is_li | w_is_ld |
                      w_is_st | w_is_b | w_is_bz | w_is_halt;

  // pc_q already points past the branch, so the offset is relative to PC+1.
  assign w_branch_tgt   = pc_q + {{8{ins_q[7]}}, ins_q[7:0]};
  assign w_branch_taken = w_is_b | (w_is_bz & PSW_Z);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= c_ST_IF;
      pc_q    <= PC_RESET;
      ins_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    case (state_q)
      c_ST_IF: begin
        if (IMem_ready) begin
          ins_d   = IMem_data;
          pc_d    = pc_q + 16'd1;
          state_d = c_ST_ID;
        end
      end
      c_ST_ID: begin
        if (!w_is_legal || w_is_nop) begin
          state_d = c_ST_IF;
        end else if (w_is_halt) begin
          state_d = c_ST_HLT;
        end else begin
          state_d = c_ST_EXE;
        end
      end
      c_ST_EXE: begin
        if (w_is_ld || w_is_st) begin
          state_d = c_ST_MEM;
        end else if (w_is_b || w_is_bz) begin
          if (w_branch_taken) begin
            pc_d = w_branch_tgt;
          end
          state_d = c_ST_IF;
        end else begin
          state_d = c_ST_WB;
        end
      end
      c_ST_MEM: begin
        state_d = w_is_ld ? c_ST_WB : c_ST_IF;
      end
      c_ST_WB: begin
        state_d = c_ST_IF;
      end
      c_ST_HLT: begin
        state_d = c_ST_HLT;
      end
      default: begin
        state_d = c_ST_IF;
      end
    endcase
  end

  // Reset gates the strobes directly so they drop in the same cycle it rises.
  always_comb begin
    IMem_req   = 1'b0;
    WBRF       = 1'b0;
    RBresource = 1'b0;
    WBresource = 1'b0;
    OprandB    = 1'b0;
    LI         = 1'b0;
    Buff_IDEXE = 1'b0;
    ALUop      = 1'b0;
    Flag       = 1'b0;
    DMem_re    = 1'b0;
    DMem_we    = 1'b0;
    Halt       = 1'b0;
    Illegal    = 1'b0;
    if (!Reset) begin
      case (state_q)
        c_ST_IF: begin
          IMem_req = 1'b1;
        end
        c_ST_ID: begin
          Buff_IDEXE = 1'b1;
          RBresource = w_is_st;
          Illegal    = ~w_is_legal;
        end
        c_ST_EXE: begin
          if (w_is_add || w_is_sub) begin
            ALUop = w_op[1];
            Flag  = 1'b1;
          end else if (w_is_li) begin
            LI      = 1'b1;
            OprandB = 1'b1;
          end else if (w_is_st) begin
            RBresource = 1'b1;
          end
        end
        c_ST_MEM: begin
          DMem_re    = w_is_ld;
          DMem_we    = w_is_st;
          RBresource = w_is_st;
        end
        c_ST_WB: begin
          WBRF       = 1'b1;
          WBresource = w_is_ld;
        end
        c_ST_HLT: begin
          Halt = 1'b1;
        end
        default: begin
          IMem_req = 1'b0;
        end
      endcase
    end
  end

  assign PC  = pc_q;
  assign Ins = ins_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl_fetch: random/directed bench with per-opcode schedule |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl_fetch;

  localparam logic [15:0] c_PC_RESET = 16'h0000;

  localparam logic [12:0] M_REQ = 13'h1000;
  localparam logic [12:0] M_WBRF = 13'h0800;
  localparam logic [12:0] M_RB  = 13'h0400;
  localparam logic [12:0] M_WBS = 13'h0200;
  localparam logic [12:0] M_OPB = 13'h0100;
  localparam logic [12:0] M_LI  = 13'h0080;
  localparam logic [12:0] M_BUF = 13'h0040;
  localparam logic [12:0] M_ALU = 13'h0020;
  localparam logic [12:0] M_FLG = 13'h0010;
  localparam logic [12:0] M_RE  = 13'h0008;
  localparam logic [12:0] M_WE  = 13'h0004;
  localparam logic [12:0] M_HLT = 13'h0002;
  localparam logic [12:0] M_ILL = 13'h0001;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] IMem_data;
  logic        IMem_ready;
  logic        PSW_Z;
  logic        IMem_req;
  logic [15:0] PC;
  logic [15:0] Ins;
  logic        WBRF, RBresource, WBresource, OprandB, LI, Buff_IDEXE;
  logic        ALUop, Flag, DMem_re, DMem_we, Halt, Illegal;

  int          n_total = 0;
  int          n_bad = 0;
  logic [15:0] pc_m;
  logic [15:0] ins_m;

  multicycle_ctrl_fetch #(.PC_RESET(c_PC_RESET)) dut (
    .clk(clk), .Reset(Reset), .IMem_data(IMem_data), .IMem_ready(IMem_ready),
    .PSW_Z(PSW_Z), .IMem_req(IMem_req), .PC(PC), .Ins(Ins), .WBRF(WBRF),
    .RBresource(RBresource), .WBresource(WBresource), .OprandB(OprandB),
    .LI(LI), .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop), .Flag(Flag),
    .DMem_re(DMem_re), .DMem_we(DMem_we), .Halt(Halt), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {IMem_req, WBRF, RBresource, WBresource, OprandB, LI, Buff_IDEXE,
            ALUop, Flag, DMem_re, DMem_we, Halt, Illegal};
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000, 5'b11111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_now(input string tag, input logic [12:0] ev);
    chk({tag, "/strobes"}, {19'd0, obs_vec()}, {19'd0, ev});
    chk({tag, "/pc"}, {16'd0, PC}, {16'd0, pc_m});
    chk({tag, "/ins"}, {16'd0, Ins}, {16'd0, ins_m});
  endtask

  task automatic cycle_chk(input string tag, input logic [12:0] ev);
    @(negedge clk);
    check_now(tag, ev);
  endtask

  task automatic hold_reset(input int cycles);
    Reset = 1'b1;
    pc_m  = c_PC_RESET;
    ins_m = 16'h0000;
    #1;
    check_now("rst_async", 13'h0);
    for (int i = 0; i < cycles; i++) cycle_chk("rst_hold", 13'h0);
    Reset = 1'b0;
  endtask

  // zmode: 0/1 force PSW_Z, 2 random; abort_mem: pulse Reset while LD is in MEM.
  task automatic run_instr(input logic [15:0] ins, input int waits, input int zmode,
                           input bit abort_mem);
    logic [4:0]  op;
    logic [12:0] sched[$];
    logic        taken;
    op = ins[15:11];
    for (int w = 0; w < waits; w++) begin
      cycle_chk("if_wait", M_REQ);
      IMem_ready = 1'b0;
      IMem_data  = 16'($urandom);
    end
    cycle_chk("if", M_REQ);
    IMem_ready = 1'b1;
    IMem_data  = ins;
    pc_m  = pc_m + 16'd1;
    ins_m = ins;
    cycle_chk("id", M_BUF | ((op == 5'b00110) ? M_RB : 13'h0) |
                    (is_legal(op) ? 13'h0 : M_ILL));
    IMem_ready = 1'b0;
    IMem_data  = 16'($urandom);
    case (op)
      5'b00001: sched = '{M_FLG, M_WBRF};
      5'b00010: sched = '{M_FLG | M_ALU, M_WBRF};
      5'b00100: sched = '{M_LI | M_OPB, M_WBRF};
      5'b00101: sched = '{13'h0, M_RE, M_WBRF | M_WBS};
      5'b00110: sched = '{M_RB, M_WE | M_RB};
      default:  sched = '{};
    endcase
    foreach (sched[i]) begin
      cycle_chk("stage", sched[i]);
      IMem_ready = 1'($urandom);
      if (abort_mem && sched[i] == M_RE) begin
        hold_reset(2);
        return;
      end
    end
    if (op == 5'b00111 || op == 5'b01000) begin
      cycle_chk("exe_br", 13'h0);
      PSW_Z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      taken = (op == 5'b00111) || PSW_Z;
      if (taken) pc_m = pc_m + {{8{ins[7]}}, ins[7:0]};
    end
    if (op == 5'b11111) begin
      for (int i = 0; i < 5; i++) begin
        cycle_chk("halt", M_HLT);
        IMem_ready = 1'($urandom);
      end
      hold_reset(1);
    end
  endtask

  function automatic logic [15:0] rand_ins();
    logic [4:0] legal[8];
    logic [4:0] op;
    legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00100,
              5'b00101, 5'b00110, 5'b00111, 5'b01000};
    if ($urandom_range(0, 99) < 15) begin
      do op = 5'($urandom); while (is_legal(op));
    end else begin
      op = legal[$urandom_range(0, 7)];
    end
    return {op, 11'($urandom)};
  endfunction

  initial begin
    Reset      = 1'b1;
    IMem_ready = 1'b0;
    IMem_data  = 16'h0000;
    PSW_Z      = 1'b0;
    pc_m       = c_PC_RESET;
    ins_m      = 16'h0000;
    hold_reset(3);

    run_instr(16'h0800, 0, 0, 1'b0);
    run_instr(16'h2800, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h38FE, 0, 0, 1'b0);
    run_instr(16'h40FE, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h40FE, 0, 1, 1'b0);
    run_instr(16'h3000, 3, 0, 1'b0);
    run_instr(16'h1234, 3, 0, 1'b0);
    run_instr(16'h2055, 0, 0, 1'b0);
    run_instr(16'hA800, 0, 0, 1'b0);
    run_instr(16'h2800, 1, 0, 1'b1);
    run_instr(16'h3880, 0, 0, 1'b0);
    run_instr(16'h387D, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    chk("pc_wrap", {16'd0, PC}, 32'd0);

    for (int n = 0; n < 120; n++) begin
      run_instr(rand_ins(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                2, 1'b0);
    end

    run_instr(16'hF800, 0, 0, 1'b0);
    run_instr(16'h0800, 0, 0, 1'b0);
    cycle_chk("final_if", M_REQ);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
